// File: rtl/tsmap_port_arbiter.sv
// tsmap_port_arbiter
//   Shares the single-port tsmap SRAM between the CPU load filter, the DMA
//   revocation checker and the allocator. Grants are combinational in the
//   request cycle and at most one is given per cycle. A response register
//   returns 1-cycle read data (or a write acknowledge) to the winner in the
//   following cycle.
//
//   Optional feature: define TSMAP_SNOOP_EN to broadcast every completed
//   in-range access on the snoop bus. Without it the snoop outputs are 0.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   cpu_req_i/addr_i           CPU read request
//   cpu_gnt_o/rvalid_o/rdata_o CPU grant and response
//   dma_*                      DMA read port (same roles as CPU)
//   dma_occupied_o             DMA request pending but not granted
//   alc_req_i/we_i/addr_i/wdata_i  allocator request (read or write)
//   alc_gnt_o/rvalid_o/rdata_o allocator grant and response/write ack
//   mem_cs_o/we_o/addr_o/wdata_o, mem_rdata_i  SRAM port
//   range_err_o                response belongs to an out-of-range access
//   snoop_cs_o/addr_o/rdata_o  completed in-range access broadcast
module tsmap_port_arbiter #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned TSMapSize = 2048,
  parameter int unsigned MaxWait   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 cpu_req_i,
  input  logic [AddrWidth-1:0] cpu_addr_i,
  output logic                 cpu_gnt_o,
  output logic                 cpu_rvalid_o,
  output logic [31:0]          cpu_rdata_o,

  input  logic                 dma_req_i,
  input  logic [AddrWidth-1:0] dma_addr_i,
  output logic                 dma_gnt_o,
  output logic                 dma_rvalid_o,
  output logic [31:0]          dma_rdata_o,
  output logic                 dma_occupied_o,

  input  logic                 alc_req_i,
  input  logic                 alc_we_i,
  input  logic [AddrWidth-1:0] alc_addr_i,
  input  logic [31:0]          alc_wdata_i,
  output logic                 alc_gnt_o,
  output logic                 alc_rvalid_o,
  output logic [31:0]          alc_rdata_o,

  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,

  output logic                 range_err_o,

  output logic                 snoop_cs_o,
  output logic [AddrWidth-1:0] snoop_addr_o,
  output logic [31:0]          snoop_rdata_o
);

  localparam int unsigned     CntW   = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);

  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcCpu  = 2'd1,
    SrcDma  = 2'd2,
    SrcAlc  = 2'd3
  } src_e;

  logic [CntW-1:0]      dma_wait_q, dma_wait_d;
  logic [CntW-1:0]      alc_wait_q, alc_wait_d;
  logic                 rr_dma_q, rr_dma_d;     // 1: DMA favoured on a tie
  logic                 rsp_valid_q, rsp_valid_d;
  src_e                 rsp_src_q, rsp_src_d;
  logic                 rsp_we_q, rsp_we_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 dma_starved, alc_starved;
  src_e                 win;
  logic [AddrWidth-1:0] sel_addr;
  logic                 in_range;
  logic                 rsp_live;
  logic [31:0]          rsp_rdata;

  // Request cycle: arbitration and SRAM command
  assign dma_starved = dma_req_i && (dma_wait_q == CntMax);
  assign alc_starved = alc_req_i && (alc_wait_q == CntMax);

  // Reset outranks every request, so nothing is granted while rst_i is high.
  always_comb begin
    win = SrcNone;
    if (rst_i)                            win = SrcNone;
    else if (dma_starved && alc_starved)  win = rr_dma_q ? SrcDma : SrcAlc;
    else if (dma_starved)                 win = SrcDma;
    else if (alc_starved)                 win = SrcAlc;
    else if (cpu_req_i)                   win = SrcCpu;
    else if (dma_req_i && alc_req_i)      win = rr_dma_q ? SrcDma : SrcAlc;
    else if (dma_req_i)                   win = SrcDma;
    else if (alc_req_i)                   win = SrcAlc;
  end

  always_comb begin
    sel_addr = '0;
    case (win)
      SrcCpu:  sel_addr = cpu_addr_i;
      SrcDma:  sel_addr = dma_addr_i;
      SrcAlc:  sel_addr = alc_addr_i;
      default: sel_addr = '0;
    endcase
  end

  assign in_range = (32'(sel_addr) < TSMapSize);

  assign cpu_gnt_o      = (win == SrcCpu);
  assign dma_gnt_o      = (win == SrcDma);
  assign alc_gnt_o      = (win == SrcAlc);
  assign dma_occupied_o = !rst_i && dma_req_i && !dma_gnt_o;

  assign mem_cs_o    = (win != SrcNone) && in_range;
  assign mem_we_o    = mem_cs_o && (win == SrcAlc) && alc_we_i;
  assign mem_addr_o  = mem_cs_o ? sel_addr : '0;
  assign mem_wdata_o = mem_we_o ? alc_wdata_i : '0;

  // Wait counters restart whenever the request is served or withdrawn and
  // stick at MaxWait so a starved requester stays first in line.
  assign dma_wait_d = (!dma_req_i || (win == SrcDma)) ? '0 :
                      (dma_wait_q == CntMax) ? CntMax : dma_wait_q + CntW'(1);
  assign alc_wait_d = (!alc_req_i || (win == SrcAlc)) ? '0 :
                      (alc_wait_q == CntMax) ? CntMax : alc_wait_q + CntW'(1);

  always_comb begin
    rr_dma_d = rr_dma_q;
    if (win == SrcDma)      rr_dma_d = 1'b0;
    else if (win == SrcAlc) rr_dma_d = 1'b1;
  end

  assign rsp_valid_d = (win != SrcNone);
  assign rsp_src_d   = win;
  assign rsp_we_d    = (win == SrcAlc) && alc_we_i;
  assign rsp_err_d   = !in_range;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dma_wait_q  <= '0;
      alc_wait_q  <= '0;
      rr_dma_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      dma_wait_q  <= dma_wait_d;
      alc_wait_q  <= alc_wait_d;
      rr_dma_q    <= rr_dma_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Response cycle: payload qualified by rsp_valid_q
`ifdef TSMAP_SNOOP_EN
  logic [AddrWidth-1:0] rsp_addr_q;
  logic [31:0]          rsp_wdata_q;
`endif

  always_ff @(posedge clk_i) begin
    rsp_src_q   <= rsp_src_d;
    rsp_we_q    <= rsp_we_d;
    rsp_err_q   <= rsp_err_d;
`ifdef TSMAP_SNOOP_EN
    rsp_addr_q  <= sel_addr;
    rsp_wdata_q <= alc_wdata_i;
`endif
  end

  // An access caught by reset in its response cycle is dropped silently.
  assign rsp_live  = rsp_valid_q && !rst_i;
  assign rsp_rdata = (rsp_we_q || rsp_err_q) ? '0 : mem_rdata_i;

  assign cpu_rvalid_o = rsp_live && (rsp_src_q == SrcCpu);
  assign dma_rvalid_o = rsp_live && (rsp_src_q == SrcDma);
  assign alc_rvalid_o = rsp_live && (rsp_src_q == SrcAlc);
  assign cpu_rdata_o  = cpu_rvalid_o ? rsp_rdata : '0;
  assign dma_rdata_o  = dma_rvalid_o ? rsp_rdata : '0;
  assign alc_rdata_o  = alc_rvalid_o ? rsp_rdata : '0;
  assign range_err_o  = rsp_live && rsp_err_q;

`ifdef TSMAP_SNOOP_EN
  assign snoop_cs_o    = rsp_live && !rsp_err_q;
  assign snoop_addr_o  = snoop_cs_o ? rsp_addr_q : '0;
  assign snoop_rdata_o = !snoop_cs_o ? '0 :
                         rsp_we_q    ? rsp_wdata_q : mem_rdata_i;
`else
  assign snoop_cs_o    = 1'b0;
  assign snoop_addr_o  = '0;
  assign snoop_rdata_o = '0;
`endif

endmodule

// File: tb/tb_tsmap_port_arbiter.sv
// Bench for tsmap_port_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the arbiter
// and an SRAM content map.
module tb_tsmap_port_arbiter;
  localparam int AW = 16;
  localparam int TS = 2048;
  localparam int MW = 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          cpu_req_i;
  logic [AW-1:0] cpu_addr_i;
  logic          cpu_gnt_o, cpu_rvalid_o;
  logic [31:0]   cpu_rdata_o;
  logic          dma_req_i;
  logic [AW-1:0] dma_addr_i;
  logic          dma_gnt_o, dma_rvalid_o, dma_occupied_o;
  logic [31:0]   dma_rdata_o;
  logic          alc_req_i, alc_we_i;
  logic [AW-1:0] alc_addr_i;
  logic [31:0]   alc_wdata_i;
  logic          alc_gnt_o, alc_rvalid_o;
  logic [31:0]   alc_rdata_o;
  logic          mem_cs_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;
  logic          range_err_o, snoop_cs_o;
  logic [AW-1:0] snoop_addr_o;
  logic [31:0]   snoop_rdata_o;

  tsmap_port_arbiter #(.AddrWidth(AW), .TSMapSize(TS), .MaxWait(MW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_gnt_o(cpu_gnt_o),
    .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .dma_req_i(dma_req_i), .dma_addr_i(dma_addr_i), .dma_gnt_o(dma_gnt_o),
    .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
    .dma_occupied_o(dma_occupied_o),
    .alc_req_i(alc_req_i), .alc_we_i(alc_we_i), .alc_addr_i(alc_addr_i),
    .alc_wdata_i(alc_wdata_i), .alc_gnt_o(alc_gnt_o),
    .alc_rvalid_o(alc_rvalid_o), .alc_rdata_o(alc_rdata_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .range_err_o(range_err_o),
    .snoop_cs_o(snoop_cs_o), .snoop_addr_o(snoop_addr_o),
    .snoop_rdata_o(snoop_rdata_o)
  );

  // Power-on contents of every tsmap word; word 0x10 holds 0xA5A5_0001.
  function automatic logic [31:0] init_word(input int a);
    return 32'hA5A5_0011 ^ 32'(a);
  endfunction

  // SRAM model: one access per select, read data one cycle later.
  logic [31:0] sram [0:TS-1];
  bit          sram_wr [0:TS-1];
  always @(posedge clk) begin
    if (mem_cs_o) begin
      if (mem_we_o) begin
        sram[mem_addr_o[10:0]]    <= mem_wdata_o;
        sram_wr[mem_addr_o[10:0]] <= 1'b1;
      end else begin
        mem_rdata_i <= sram_wr[mem_addr_o[10:0]] ? sram[mem_addr_o[10:0]]
                                                 : init_word(int'(mem_addr_o));
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          wd = 0, wa = 0;         // cycles each requester has lost
  bit          fav_dma = 1'b1;         // tie-break favours DMA
  bit          pv = 1'b0;              // a response is due this cycle
  int          ps, pa;                 // its source (1 cpu,2 dma,3 alc), address
  bit          perr, pwe;
  logic [31:0] pdata, psnoop;
  int          g = 0;                  // expected winner this cycle, 0 none
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic int pick();
    bit ds = dma_req_i && (wd == MW);
    bit as = alc_req_i && (wa == MW);
    if (ds && as) return fav_dma ? 2 : 3;
    if (ds) return 2;
    if (as) return 3;
    if (cpu_req_i) return 1;
    if (dma_req_i && alc_req_i) return fav_dma ? 2 : 3;
    if (dma_req_i) return 2;
    if (alc_req_i) return 3;
    return 0;
  endfunction

  function automatic int addr_of(input int s);
    if (s == 1) return int'(cpu_addr_i);
    if (s == 2) return int'(dma_addr_i);
    return int'(alc_addr_i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare every output with the model midway through the cycle.
  task automatic settle();
    int  a;
    bit  inr, live, wexp;
    @(negedge clk);
    g    = rst_i ? 0 : pick();
    a    = (g == 0) ? 0 : addr_of(g);
    inr  = (g != 0) && (a < TS);
    wexp = inr && (g == 3) && alc_we_i;
    chk1("cpu_gnt", cpu_gnt_o, g == 1);
    chk1("dma_gnt", dma_gnt_o, g == 2);
    chk1("alc_gnt", alc_gnt_o, g == 3);
    chk1("dma_occupied", dma_occupied_o, !rst_i && dma_req_i && (g != 2));
    chk1("mem_cs", mem_cs_o, inr);
    chk1("mem_we", mem_we_o, wexp);
    if (inr)  chk("mem_addr", 32'(mem_addr_o), 32'(a));
    if (wexp) chk("mem_wdata", mem_wdata_o, alc_wdata_i);
    live = pv && !rst_i;
    chk1("cpu_rvalid", cpu_rvalid_o, live && ps == 1);
    chk1("dma_rvalid", dma_rvalid_o, live && ps == 2);
    chk1("alc_rvalid", alc_rvalid_o, live && ps == 3);
    chk("cpu_rdata", cpu_rdata_o, (live && ps == 1) ? pdata : 32'h0);
    chk("dma_rdata", dma_rdata_o, (live && ps == 2) ? pdata : 32'h0);
    chk("alc_rdata", alc_rdata_o, (live && ps == 3) ? pdata : 32'h0);
    chk1("range_err", range_err_o, live && perr);
`ifdef TSMAP_SNOOP_EN
    chk1("snoop_cs", snoop_cs_o, live && !perr);
    if (live && !perr) begin
      chk("snoop_addr", 32'(snoop_addr_o), 32'(pa));
      chk("snoop_rdata", snoop_rdata_o, psnoop);
    end
`else
    chk1("snoop_cs", snoop_cs_o, 1'b0);
    chk("snoop_addr", 32'(snoop_addr_o), 32'h0);
    chk("snoop_rdata", snoop_rdata_o, 32'h0);
`endif
  endtask

  // Advance the model across the clock edge using the winner seen in settle().
  task automatic edge_update();
    int a;
    @(posedge clk);
    if (rst_i) begin
      wd = 0; wa = 0; fav_dma = 1'b1; pv = 1'b0;
    end else begin
      pv = (g != 0);
      if (g != 0) begin
        a      = addr_of(g);
        ps     = g;
        pa     = a;
        perr   = (a >= TS);
        pwe    = (g == 3) && alc_we_i;
        pdata  = (perr || pwe) ? 32'h0 : rd(a);
        psnoop = pwe ? alc_wdata_i : rd(a);
        if (pwe && !perr) ref_mem[a] = alc_wdata_i;
      end
      wd = (!dma_req_i || g == 2) ? 0 : ((wd < MW) ? wd + 1 : MW);
      wa = (!alc_req_i || g == 3) ? 0 : ((wa < MW) ? wa + 1 : MW);
      if (g == 2) fav_dma = 1'b0;
      if (g == 3) fav_dma = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    cpu_req_i = 1'b0; cpu_addr_i = '0;
    dma_req_i = 1'b0; dma_addr_i = '0;
    alc_req_i = 1'b0; alc_we_i = 1'b0; alc_addr_i = '0; alc_wdata_i = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r = $urandom_range(0, 15);
    if (r == 0) return AW'(TS + $urandom_range(0, 3));
    if (r == 1) return 16'hFFFF;
    return AW'($urandom_range(0, 47));
  endfunction

  function automatic logic quiet();
    return |{cpu_gnt_o, dma_gnt_o, alc_gnt_o, cpu_rvalid_o, dma_rvalid_o,
             alc_rvalid_o, dma_occupied_o, mem_cs_o, mem_we_o, range_err_o,
             snoop_cs_o, cpu_rdata_o, dma_rdata_o, alc_rdata_o, mem_addr_o,
             mem_wdata_o, snoop_addr_o, snoop_rdata_o};
  endfunction

  initial begin
    int ngnt, nocc;
    int gq[$];
    idle();
    rst_i = 1'b1;

    // Reset, then idle
    settle(); chk1("reset_outputs_zero", quiet(), 1'b0); edge_update();
    settle(); edge_update();
    rst_i = 1'b0;
    settle(); chk1("idle_outputs_zero", quiet(), 1'b0); edge_update();

    // Single CPU read of 0x10
    cpu_req_i = 1'b1; cpu_addr_i = 16'h0010;
    settle(); chk1("t1_cpu_gnt", cpu_gnt_o, 1'b1); edge_update();
    idle();
    settle();
    chk1("t1_cpu_rvalid", cpu_rvalid_o, 1'b1);
    chk("t1_cpu_rdata", cpu_rdata_o, 32'hA5A5_0001);
    edge_update();

    // CPU and DMA both requesting without pause
    cpu_req_i = 1'b1; cpu_addr_i = 16'h0030;
    dma_req_i = 1'b1; dma_addr_i = 16'h0031;
    ngnt = 0; nocc = 0;
    for (int i = 0; i < 27; i++) begin
      settle();
      if (dma_gnt_o) begin ngnt++; gq.push_back(i); end
      if (dma_occupied_o) nocc++;
      edge_update();
    end
    chk("t2_dma_grant_count", ngnt, 3);
    chk("t2_dma_occupied_count", nocc, 24);
    foreach (gq[k]) chk("t2_dma_grant_cycle", gq[k], 8 + 9 * k);

    // Reset, then DMA and allocator contend with no CPU
    idle(); rst_i = 1'b1;
    settle(); edge_update();
    rst_i = 1'b0;
    dma_req_i = 1'b1; dma_addr_i = 16'h0040;
    alc_req_i = 1'b1; alc_we_i = 1'b0; alc_addr_i = 16'h0041;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk1("t3_dma_turn", dma_gnt_o, (i % 2) == 0);
      chk1("t3_alc_turn", alc_gnt_o, (i % 2) == 1);
      edge_update();
    end

    // Allocator write then DMA read of the same word
    idle(); settle(); edge_update();
    alc_req_i = 1'b1; alc_we_i = 1'b1; alc_addr_i = 16'h0020; alc_wdata_i = 32'h4;
    settle();
    chk1("t4_alc_gnt", alc_gnt_o, 1'b1);
    chk1("t4_mem_we", mem_we_o, 1'b1);
    edge_update();
    idle(); dma_req_i = 1'b1; dma_addr_i = 16'h0020;
    settle();
    chk1("t4_dma_gnt", dma_gnt_o, 1'b1);
    chk1("t4_alc_wr_ack", alc_rvalid_o, 1'b1);
`ifdef TSMAP_SNOOP_EN
    chk1("t4_snoop_wr_cs", snoop_cs_o, 1'b1);
    chk("t4_snoop_wr_addr", 32'(snoop_addr_o), 32'h20);
    chk("t4_snoop_wr_data", snoop_rdata_o, 32'h4);
`endif
    edge_update();
    idle();
    settle();
    chk1("t4_dma_rvalid", dma_rvalid_o, 1'b1);
    chk("t4_dma_rdata", dma_rdata_o, 32'h4);
`ifdef TSMAP_SNOOP_EN
    chk1("t4_snoop_rd_cs", snoop_cs_o, 1'b1);
    chk("t4_snoop_rd_data", snoop_rdata_o, 32'h4);
`endif
    edge_update();

    // DMA read just past the end of the map
    dma_req_i = 1'b1; dma_addr_i = 16'd2048;
    settle();
    chk1("t5_dma_gnt", dma_gnt_o, 1'b1);
    chk1("t5_no_mem_cs", mem_cs_o, 1'b0);
    edge_update();
    idle();
    settle();
    chk1("t5_dma_rvalid", dma_rvalid_o, 1'b1);
    chk("t5_dma_rdata", dma_rdata_o, 32'h0);
    chk1("t5_range_err", range_err_o, 1'b1);
    chk1("t5_no_snoop", snoop_cs_o, 1'b0);
    edge_update();

    // Reset lands in the response cycle of a CPU read
    cpu_req_i = 1'b1; cpu_addr_i = 16'h0010;
    settle(); chk1("t6_cpu_gnt", cpu_gnt_o, 1'b1); edge_update();
    idle(); rst_i = 1'b1;
    settle(); chk1("t6_no_rvalid_in_reset", cpu_rvalid_o, 1'b0); edge_update();
    rst_i = 1'b0;
    settle();
    chk1("t6_no_rvalid_after", cpu_rvalid_o, 1'b0);
    chk1("t6_outputs_zero", quiet(), 1'b0);
    edge_update();

    // Randomized traffic; a losing request is held until it is granted
    for (int c = 0; c < 3000; c++) begin
      settle();
      edge_update();
      if (!(cpu_req_i && g != 1 && !rst_i)) begin
        cpu_req_i  = ($urandom_range(0, 9) < 7);
        cpu_addr_i = rand_addr();
      end
      if (!(dma_req_i && g != 2 && !rst_i)) begin
        dma_req_i  = ($urandom_range(0, 9) < 6);
        dma_addr_i = rand_addr();
      end
      if (!(alc_req_i && g != 3 && !rst_i)) begin
        alc_req_i   = ($urandom_range(0, 9) < 5);
        alc_we_i    = $urandom_range(0, 1) == 1;
        alc_addr_i  = rand_addr();
        alc_wdata_i = $urandom;
      end
      rst_i = ($urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
